// File: rtl/multi_byte_add_seq.sv
// Byte-serial add/subtract sequencer wrapped around one external 8-bit full adder.
// Operands are latched on start and fed LSB first; sum bytes and the carry chain are registered.
module multi_byte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic                cin,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  output logic [7:0]          fa_a,
  output logic [7:0]          fa_b,
  output logic                fa_cin,
  input  logic [7:0]          fa_sum,
  input  logic                fa_co,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                ovf
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [IDX_W-1:0] idx_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic             carry_r;
  logic [W-1:0]     result_r;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  logic [7:0]       fa_a_s;
  logic [7:0]       fa_b_s;
  logic             fa_cin_s;
  logic             last_s;
  logic             ovf_s;

  assign last_s = (idx_r == LAST_IDX);
  // Both latched MSBs agree but the top sum bit differs: signed overflow (B already inverted for sub).
  assign ovf_s  = (a_r[W-1] == b_r[W-1]) && (fa_sum[7] != a_r[W-1]);

  // Adder drive: current operand byte pair and chained carry while running, quiet otherwise.
  always_comb begin
    fa_a_s   = 8'h00;
    fa_b_s   = 8'h00;
    fa_cin_s = 1'b0;
    if (state_r == ST_RUN) begin
      fa_a_s   = a_r[8*idx_r +: 8];
      fa_b_s   = b_r[8*idx_r +: 8];
      fa_cin_s = carry_r;
    end else begin
      fa_a_s   = 8'h00;
      fa_b_s   = 8'h00;
      fa_cin_s = 1'b0;
    end
  end

  // Sequencer FSM: operand capture, per-byte result/carry update and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      idx_r    <= '0;
      a_r      <= '0;
      b_r      <= '0;
      carry_r  <= 1'b0;
      result_r <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
            idx_r   <= '0;
            a_r     <= op_a;
            b_r     <= sub ? ~op_b : op_b;
            carry_r <= sub ? 1'b1 : cin;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          result_r[8*idx_r +: 8] <= fa_sum;
          carry_r                <= fa_co;
          idx_r                  <= idx_r + IDX_W'(1);
          if (last_s) begin
            cout_r  <= fa_co;
            ovf_r   <= ovf_s;
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= '0;
          carry_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign fa_a   = fa_a_s;
  assign fa_b   = fa_b_s;
  assign fa_cin = fa_cin_s;
  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign cout   = cout_r;
  assign ovf    = ovf_r;

endmodule

// File: tb/tb_multi_byte_add_seq.sv
// Self-checking bench for multi_byte_add_seq with an 8-bit adder model and arithmetic reference.
module tb_multi_byte_add_seq;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [7:0]   fa_a;
  logic [7:0]   fa_b;
  logic         fa_cin;
  logic [7:0]   fa_sum;
  logic         fa_co;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int nchk;
  int nerr;

  multi_byte_add_seq #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
    .op_a(op_a), .op_b(op_b), .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_co(fa_co), .busy(busy), .done(done),
    .result(result), .cout(cout), .ovf(ovf)
  );

  // External combinational 8-bit full adder.
  assign {fa_co, fa_sum} = {1'b0, fa_a} + {1'b0, fa_b} + {8'h00, fa_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {ovf, cout, result} from plain W-bit arithmetic.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s, input logic c);
    logic [W:0]   full;
    logic         v;
    if (!s) begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      v    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    end else begin
      full[W-1:0] = a - b;
      full[W]     = (a >= b);
      v           = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    end
    return {v, full};
  endfunction

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic c);
    logic [W+1:0] exp;
    int lat;
    int busy_n;
    exp = ref_op(a, b, s, c);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
    lat = 1; busy_n = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
    nchk++;
    if (lat !== 5) begin $display("FAIL %s latency got %0d want 5", name, lat); nerr++; end
    nchk++;
    if (busy_n !== 4) begin $display("FAIL %s busy_cycles got %0d want 4", name, busy_n); nerr++; end
    nchk++;
    if (result !== exp[W-1:0]) begin $display("FAIL %s result got %h want %h", name, result, exp[W-1:0]); nerr++; end
    nchk++;
    if (cout !== exp[W]) begin $display("FAIL %s cout got %b want %b", name, cout, exp[W]); nerr++; end
    nchk++;
    if (ovf !== exp[W+1]) begin $display("FAIL %s ovf got %b want %b", name, ovf, exp[W+1]); nerr++; end
    @(negedge clk);
    nchk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL %s done_pulse got done=%b busy=%b want 0 0", name, done, busy); nerr++;
    end
    nchk++;
    if (result !== exp[W-1:0]) begin $display("FAIL %s result_hold got %h want %h", name, result, exp[W-1:0]); nerr++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    nchk++;
    if ({busy, done, result, cout, ovf, fa_a, fa_b, fa_cin} !== '0) begin
      $display("FAIL reset_outputs got busy=%b done=%b result=%h cout=%b ovf=%b fa=%h/%h/%b want all 0",
               busy, done, result, cout, ovf, fa_a, fa_b, fa_cin);
      nerr++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op("carry_chain", 32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    do_op("full_ripple", 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1);
    do_op("signed_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    do_op("sub_borrow",  32'h00000005, 32'h00000007, 1'b1, 1'b1);
    do_op("sub_ovf",     32'h80000000, 32'h00000001, 1'b1, 1'b0);
    nchk++;
    if (fa_a !== 8'h00 || fa_b !== 8'h00 || fa_cin !== 1'b0) begin
      $display("FAIL idle_fa got %h/%h/%b want 0/0/0", fa_a, fa_b, fa_cin); nerr++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      do_op("random", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_start_while_busy();
    logic [W+1:0] exp;
    int lat;
    exp = ref_op(32'h01020304, 32'h10203040, 1'b0, 1'b1);
    @(negedge clk);
    op_a = 32'h01020304; op_b = 32'h10203040; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op_a = 32'hDEADBEEF; op_b = 32'h0BADF00D; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    nchk++;
    if (lat !== 5) begin $display("FAIL busy_start latency got %0d want 5", lat); nerr++; end
    nchk++;
    if (result !== exp[W-1:0] || cout !== exp[W]) begin
      $display("FAIL busy_start result got %h/%b want %h/%b", result, cout, exp[W-1:0], exp[W]); nerr++;
    end
    repeat (6) begin
      @(negedge clk);
      nchk++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        $display("FAIL busy_start extra_op got busy=%b done=%b want 0 0", busy, done); nerr++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    op_a = 32'h00000AAA; op_b = 32'h00000555; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    nchk++;
    if (done !== 1'b1 || result !== 32'h00000FFF) begin
      $display("FAIL b2b_first got done=%b result=%h want 1 00000fff", done, result); nerr++;
    end
    op_a = 32'h00000010; op_b = 32'h00000020; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nchk++;
    if (busy !== 1'b1) begin $display("FAIL b2b_accept busy got %b want 1", busy); nerr++; end
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    nchk++;
    if (lat !== 5 || result !== 32'h00000030 || cout !== 1'b0) begin
      $display("FAIL b2b_second got lat=%0d result=%h cout=%b want 5 00000030 0", lat, result, cout); nerr++;
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    op_a = 32'hFFFFFFFF; op_b = 32'h00000001; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({busy, done, result, cout, ovf, fa_a, fa_b, fa_cin} !== '0) begin
      $display("FAIL mid_reset got busy=%b done=%b result=%h cout=%b ovf=%b fa=%h/%h/%b want all 0",
               busy, done, result, cout, ovf, fa_a, fa_b, fa_cin);
      nerr++;
    end
    repeat (6) begin
      @(negedge clk);
      nchk++;
      if (done !== 1'b0) begin $display("FAIL mid_reset_done got %b want 0", done); nerr++; end
    end
    rst_n = 1'b1;
    do_op("after_reset", 32'h12345678, 32'h11111111, 1'b0, 1'b0);
    nchk++;
    if (result !== 32'h23456789) begin
      $display("FAIL after_reset_const got %h want 23456789", result); nerr++;
    end
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/multi_byte_add_seq.md
Name: multi_byte_add_seq

Overview:
- Byte-serial sequencer that adds or subtracts two NBYTES-wide operands using one external combinational 8-bit full adder.
- Sits directly around the 8-bit adder. It drives the adder's a, b and cin inputs one byte per clock, least significant byte first.
- It captures the adder's sum and carry-out into a result register and chains the carry between bytes.
- It presents a start/busy/done handshake to the control logic upstream.

Parameters:
NBYTES, 4, number of 8-bit bytes per operand (>=2); operand width W = 8*NBYTES

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
sub  input  1  0 = add, 1 = subtract (op_a - op_b); latched on start
cin  input  1  carry-in for add; ignored when sub=1; latched on start
op_a  input  W  operand A; latched on start
op_b  input  W  operand B; latched on start
fa_a  output  8  byte of A to adder
fa_b  output  8  byte of B (inverted if sub) to adder
fa_cin  output  1  chained carry to adder
fa_sum  input  8  adder sum, combinational from fa_a/fa_b/fa_cin
fa_co  input  1  adder carry-out
busy  output  1  high in RUN
done  output  1  one-cycle pulse, result valid
result  output  W  sum/difference; held until next accepted start
cout  output  1  final carry-out (sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; byte index=0; carry reg=0. busy, done, result, cout, ovf, fa_a, fa_b, fa_cin are all 0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: on an edge with start=1.
  - Latch A = op_a.
  - Latch B = sub ? ~op_b : op_b.
  - Carry reg = sub ? 1 : cin.
  - Byte index = 0.
- RUN, combinational drive:
  - fa_a = A[8*idx +: 8]
  - fa_b = B[8*idx +: 8]
  - fa_cin = carry reg
- RUN, each edge:
  - result[8*idx +: 8] <= fa_sum
  - carry reg <= fa_co
  - idx <= idx+1
- RUN, on the edge where idx = NBYTES-1:
  - cout <= fa_co.
  - ovf <= (A msb == B msb) && (fa_sum[7] != A msb). This uses the latched B, so it is already inverted for subtraction.
  - Go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 on that edge is accepted, same as from IDLE, and goes to RUN.
  - Otherwise go to IDLE.
- Latency: start sampled at edge k. Bytes are processed on edges k+1..k+NBYTES. done is high in the cycle after edge k+NBYTES. A new start can be sampled at edge k+NBYTES+1.
- busy=1 exactly while in RUN. start is ignored in RUN, and op_a/op_b/sub/cin may change freely then.
- fa_a, fa_b, fa_cin are 0 outside RUN.
- result, cout, ovf:
  - Hold their last values through IDLE.
  - result bytes are overwritten progressively during RUN.
  - Consumers use them only when done=1 or after it.
- Arithmetic:
  - Modulo 2^W.
  - Add: result = op_a + op_b + cin.
  - Sub: result = op_a - op_b.
  - cout is bit W of the full sum.
- Mid-operation reset (rst_n low): immediately returns to reset values. No done is produced. The next start after release works normally.
- No combinational path from fa_sum/fa_co to any output except through registers.

Test Plan (NBYTES=4, external adder model connected):
- Carry chain: add, op_a=0x000000FF, op_b=0x00000001, cin=0 -> done exactly 5 cycles after the start edge (one pulse); result=0x00000100, cout=0, ovf=0; busy high for 4 cycles.
- Full carry ripple: add, op_a=0xFFFFFFFF, op_b=0x00000000, cin=1 -> result=0x00000000, cout=1, ovf=0.
- Signed overflow: add, op_a=0x7FFFFFFF, op_b=0x00000001, cin=0 -> result=0x80000000, cout=0, ovf=1.
- Subtraction with borrow:
  - sub=1, op_a=0x00000005, op_b=0x00000007, cin=1 (must be ignored) -> result=0xFFFFFFFE, cout=0, ovf=0.
  - sub=1, op_a=0x80000000, op_b=0x00000001 -> result=0x7FFFFFFF, cout=1, ovf=1.
- Handshake:
  - Pulse start again while busy with different operands -> ignored; the first result is unchanged.
  - Assert start during the done cycle with 0x00000010+0x00000020 -> accepted; next done gives 0x00000030.
- Reset mid-operation: drop rst_n after the 2nd RUN edge -> all outputs 0 immediately; no done. After release, start 0x12345678+0x11111111 -> result=0x23456789, cout=0.
